ex_muldiv_sequencer: RTL and testbench

//   Iterative HI/LO multiply/divide unit beside the EX-stage ALU.

---
 rtl/ex_muldiv_sequencer_if.sv | 32 +++
 rtl/ex_muldiv_sequencer.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
// The master side is the EX pipeline; the slave side is ex_muldiv_sequencer.
interface ex_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Stall;
    logic             Flush;
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic             ReadHiLo;
    logic             WriteHi;
    logic             WriteLo;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             ALUStall;

    modport master (
        output Stall, Flush, Start, Op, ReadData1, ReadData2,
               ReadHiLo, WriteHi, WriteLo, WriteData,
        input  Hi, Lo, Busy, ALUStall
    );

    modport slave (
        input  Stall, Flush, Start, Op, ReadData1, ReadData2,
               ReadHiLo, WriteHi, WriteLo, WriteData,
        output Hi, Lo, Busy, ALUStall
    );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Iterative radix-2 HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// magnitudes iterate and signs are applied in a final FIX cycle.
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    ex_muldiv_sequencer_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } seqState;

    seqState              stateReg;
    logic [CW-1:0]        counterReg;
    logic                 busyReg;
    logic                 isDivReg;
    logic                 negSignReg;
    logic                 negRemReg;
    logic                 divZeroReg;
    logic [WIDTH-1:0]     operandReg;
    logic [2*WIDTH-1:0]   accReg;
    logic [WIDTH-1:0]     hiReg;
    logic [WIDTH-1:0]     loReg;

    logic                 accept;
    logic                 isSigned;
    logic                 rsNeg;
    logic                 rtNeg;
    logic [WIDTH-1:0]     absRs;
    logic [WIDTH-1:0]     absRt;
    logic [2*WIDTH-1:0]   stepAcc;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       remShift;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   mulResult;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [WIDTH-1:0]     divLo;
    logic [WIDTH-1:0]     divHi;

    assign accept       = bus.Start & ~busyReg & ~bus.Stall & ~bus.Flush;
    assign bus.ALUStall = busyReg & (bus.Start | bus.ReadHiLo | bus.WriteHi | bus.WriteLo);
    assign bus.Busy     = busyReg;
    assign bus.Hi       = hiReg;
    assign bus.Lo       = loReg;

    assign isSigned = ~bus.Op[0];
    assign rsNeg    = isSigned & bus.ReadData1[WIDTH-1];
    assign rtNeg    = isSigned & bus.ReadData2[WIDTH-1];
    assign absRs    = rsNeg ? -bus.ReadData1 : bus.ReadData1;
    assign absRt    = rtNeg ? -bus.ReadData2 : bus.ReadData2;

    // One iteration. Multiply: upper half accumulates, lower half holds the
    // remaining multiplier bits. Divide: upper half is the partial remainder,
    // lower half shifts the dividend out and the quotient in.
    always_comb begin
        stepAcc  = accReg;
        sum      = '0;
        remShift = '0;
        diff     = '0;
        if (isDivReg) begin
            remShift = accReg[2*WIDTH-1:WIDTH-1];
            diff     = remShift - {1'b0, operandReg};
            if (!diff[WIDTH]) begin
                stepAcc = {diff[WIDTH-1:0], accReg[WIDTH-2:0], 1'b1};
            end else begin
                stepAcc = {remShift[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, operandReg} : '0);
            stepAcc = {sum, accReg[WIDTH-1:1]};
        end
    end

    // Divide by zero yields an all-ones quotient regardless of operand signs.
    assign mulResult = negSignReg ? -accReg : accReg;
    assign quotient  = accReg[WIDTH-1:0];
    assign remainder = accReg[2*WIDTH-1:WIDTH];
    assign divLo     = divZeroReg ? '1 : (negSignReg ? -quotient : quotient);
    assign divHi     = negRemReg ? -remainder : remainder;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= IDLE;
            counterReg <= '0;
            busyReg    <= 1'b0;
            isDivReg   <= 1'b0;
            negSignReg <= 1'b0;
            negRemReg  <= 1'b0;
            divZeroReg <= 1'b0;
            operandReg <= '0;
            accReg     <= '0;
            hiReg      <= '0;
            loReg      <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        stateReg   <= RUN;
                        busyReg    <= 1'b1;
                        counterReg <= CW'(WIDTH - 1);
                        isDivReg   <= bus.Op[1];
                        negSignReg <= rsNeg ^ rtNeg;
                        negRemReg  <= rsNeg;
                        divZeroReg <= (bus.ReadData2 == '0);
                        if (bus.Op[1]) begin
                            operandReg <= absRt;
                            accReg     <= {{WIDTH{1'b0}}, absRs};
                        end else begin
                            operandReg <= absRs;
                            accReg     <= {{WIDTH{1'b0}}, absRt};
                        end
                    end else if (!bus.Stall && !bus.Flush) begin
                        // MTHI/MTLO only land when no start is competing for the slot.
                        if (bus.WriteHi) hiReg <= bus.WriteData;
                        if (bus.WriteLo) loReg <= bus.WriteData;
                    end
                end
                RUN: begin
                    if (bus.Flush) begin
                        stateReg <= IDLE;
                        busyReg  <= 1'b0;
                    end else begin
                        accReg     <= stepAcc;
                        counterReg <= counterReg - 1'b1;
                        if (counterReg == '0) stateReg <= FIX;
                    end
                end
                FIX: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                    if (!bus.Flush) begin
                        if (isDivReg) begin
                            hiReg <= divHi;
                            loReg <= divLo;
                        end else begin
                            hiReg <= mulResult[2*WIDTH-1:WIDTH];
                            loReg <= mulResult[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: stimulus pushes expected HI/LO,
// a monitor pops and compares each time Busy falls.
module tb_ex_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ex_muldiv_sequencer_if #(.WIDTH(W)) bus();

    ex_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          id;
    } expEntry;

    expEntry     sb[$];
    int          tests  = 0;
    int          failed = 0;
    int          txn    = 0;
    logic [31:0] mHi    = '0;
    logic [31:0] mLo    = '0;
    logic        prevBusy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb2;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (op)
            2'b00: begin
                p = sa * sb2;
                return p;
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return p;
            end
            default: begin
                if (b == 32'd0) return {a, 32'hffff_ffff};
                if (op == 2'b10) begin
                    q = sa / sb2;
                    r = sa % sb2;
                end else begin
                    q = longint'({32'b0, a}) / longint'({32'b0, b});
                    r = longint'({32'b0, a}) % longint'({32'b0, b});
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic pushExp(input logic [31:0] hi, input logic [31:0] lo);
        expEntry e;
        txn++;
        e.hi = hi;
        e.lo = lo;
        e.id = txn;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic alsoMthi);
        @(negedge clk);
        bus.Stall     = 1'b0;
        bus.Flush     = 1'b0;
        bus.Start     = 1'b1;
        bus.Op        = op;
        bus.ReadData1 = a;
        bus.ReadData2 = b;
        bus.WriteHi   = alsoMthi;
        bus.WriteData = 32'hcafe_f00d;
        @(negedge clk);
        bus.Start   = 1'b0;
        bus.WriteHi = 1'b0;
        check("accept_busy", {31'b0, bus.Busy}, 32'd1);
    endtask

    task automatic waitIdle(input bit randStall, output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            n++;
            if (randStall) bus.Stall = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.Stall = 1'b0;
        if (n >= 100) check("busy_timeout", 32'd100, 32'd33);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit randStall);
        logic [63:0] r;
        int          n;
        r   = model(op, a, b);
        mHi = r[63:32];
        mLo = r[31:0];
        pushExp(mHi, mLo);
        issue(op, a, b, 1'b0);
        waitIdle(randStall, n);
        check("latency", n, 32'd33);
    endtask

    task automatic mtWrite(input logic hi, input logic [31:0] d);
        @(negedge clk);
        bus.WriteHi   = hi;
        bus.WriteLo   = ~hi;
        bus.WriteData = d;
        @(negedge clk);
        bus.WriteHi = 1'b0;
        bus.WriteLo = 1'b0;
        if (hi) begin
            mHi = d;
            check("mthi", bus.Hi, mHi);
        end else begin
            mLo = d;
            check("mtlo", bus.Lo, mLo);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every falling edge of Busy retires one scoreboard entry.
    always @(negedge clk) begin
        expEntry e;
        if (prevBusy && !bus.Busy) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result_hi", bus.Hi, e.hi);
                check("result_lo", bus.Lo, e.lo);
                $display("[TB] txn %0d hi=%h lo=%h (exp hi=%h lo=%h)", e.id, bus.Hi, bus.Lo, e.hi, e.lo);
            end
        end
        prevBusy = bus.Busy;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          stallCnt;
        logic [1:0]  op;
        logic [63:0] r;

        bus.Stall = 0; bus.Flush = 0; bus.Start = 0; bus.Op = 0;
        bus.ReadData1 = 0; bus.ReadData2 = 0; bus.ReadHiLo = 0;
        bus.WriteHi = 0; bus.WriteLo = 0; bus.WriteData = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state; ALUStall stays low while idle even with a HI/LO read pending.
        @(negedge clk);
        bus.ReadHiLo = 1'b1;
        #1;
        check("reset_hi", bus.Hi, 32'd0);
        check("reset_lo", bus.Lo, 32'd0);
        check("reset_busy", {31'b0, bus.Busy}, 32'd0);
        check("idle_alustall", {31'b0, bus.ALUStall}, 32'd0);
        bus.ReadHiLo = 1'b0;

        // Directed arithmetic cases with spec constants.
        runOp(2'b01, 32'hffff_ffff, 32'hffff_ffff, 1'b0);
        check("multu_hi", bus.Hi, 32'hffff_fffe);
        check("multu_lo", bus.Lo, 32'h0000_0001);
        runOp(2'b00, -32'sd3, 32'd7, 1'b0);
        check("mult_neg_lo", bus.Lo, 32'hffff_ffeb);
        runOp(2'b10, -32'sd7, 32'd2, 1'b0);
        check("div_neg_lo", bus.Lo, 32'hffff_fffd);
        check("div_neg_hi", bus.Hi, 32'hffff_ffff);
        runOp(2'b11, 32'd100, 32'd7, 1'b0);
        check("divu_lo", bus.Lo, 32'd14);
        check("divu_hi", bus.Hi, 32'd2);

        // MFHI one cycle after accept, plus an MTHI attempt while busy.
        r = model(2'b11, 32'd100000, 32'd13);
        mHi = r[63:32]; mLo = r[31:0];
        pushExp(mHi, mLo);
        issue(2'b11, 32'd100000, 32'd13, 1'b0);
        bus.ReadHiLo = 1'b1;
        stallCnt = 0;
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            #1;
            if (bus.ALUStall) stallCnt++;
            n++;
            if (n == 3) begin bus.WriteHi = 1'b1; bus.WriteData = 32'hdead_beef; end
            if (n == 5) bus.WriteHi = 1'b0;
            @(negedge clk);
        end
        #1;
        check("alustall_after_busy", {31'b0, bus.ALUStall}, 32'd0);
        bus.ReadHiLo = 1'b0;
        check("alustall_cycles", stallCnt, 32'd33);

        // Boundary cases.
        runOp(2'b10, 32'd5, 32'd0, 1'b0);
        check("div0_lo", bus.Lo, 32'hffff_ffff);
        check("div0_hi", bus.Hi, 32'd5);
        runOp(2'b10, -32'sd9, 32'd0, 1'b0);
        runOp(2'b11, 32'hffff_0000, 32'd0, 1'b0);
        runOp(2'b10, 32'h8000_0000, 32'hffff_ffff, 1'b0);
        check("ovf_lo", bus.Lo, 32'h8000_0000);
        check("ovf_hi", bus.Hi, 32'd0);
        runOp(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("minmul_hi", bus.Hi, 32'h4000_0000);
        check("minmul_lo", bus.Lo, 32'd0);

        // MTLO while idle, then MULT flushed in RUN cycle 10.
        mtWrite(1'b0, 32'h1234);
        pushExp(mHi, mLo);
        issue(2'b00, 32'd77, 32'd99, 1'b0);
        repeat (9) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check("flush_busy", {31'b0, bus.Busy}, 32'd0);
        check("flush_lo", bus.Lo, 32'h1234);
        check("flush_hi", bus.Hi, mHi);

        // Accept coinciding with MTHI drops the write; flush keeps old HI.
        pushExp(mHi, mLo);
        issue(2'b01, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check("mthi_dropped", bus.Hi, mHi);

        // Flush during FIX suppresses the write.
        pushExp(mHi, mLo);
        issue(2'b01, 32'd1000, 32'd1000, 1'b0);
        repeat (32) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check("fixflush_busy", {31'b0, bus.Busy}, 32'd0);
        check("fixflush_lo", bus.Lo, mLo);

        // Start held under Stall is not accepted.
        @(negedge clk);
        bus.Stall = 1'b1; bus.Start = 1'b1; bus.Op = 2'b10;
        bus.ReadData1 = -32'sd100; bus.ReadData2 = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_accept", {31'b0, bus.Busy}, 32'd0);
        end
        r = model(2'b10, -32'sd100, 32'd7);
        mHi = r[63:32]; mLo = r[31:0];
        pushExp(mHi, mLo);
        bus.Stall = 1'b0;
        @(negedge clk);
        bus.Start = 1'b0;
        check("stall_release_accept", {31'b0, bus.Busy}, 32'd1);
        waitIdle(1'b0, n);
        check("stall_latency", n, 32'd33);

        // Randomized operations with pipeline stall toggling during RUN.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) mtWrite(1'($urandom_range(0, 1)), $urandom);
            op = 2'($urandom_range(0, 3));
            runOp(op, pickOperand(), pickOperand(), 1'b1);
        end

        // Reset mid-RUN clears HI/LO and Busy immediately.
        pushExp(32'd0, 32'd0);
        issue(2'b00, 32'd12345, 32'd678, 1'b0);
        repeat (12) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", {31'b0, bus.Busy}, 32'd0);
        check("rst_hi", bus.Hi, 32'd0);
        check("rst_lo", bus.Lo, 32'd0);
        mHi = 0; mLo = 0;
        @(negedge clk);
        reset = 1'b0;
        runOp(2'b11, 32'd1000, 32'd33, 1'b0);

        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
